// File: rtl/kmi_pkg.sv
// Shared types and default timing constants for the KMI line sequencer.
`timescale 1ns/1ps
package kmi_pkg;

  // State encodings are visible on the status port, so the values are fixed
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX      = 3'd1,
    INHIBIT = 3'd2,
    RTS     = 3'd3,
    TX      = 3'd4,
    RECOVER = 3'd5
  } kmi_seq_state_t;

  // Defaults for an 8 MHz reference clock: 100 us inhibit, 2 us RTS, 2 ms timeout
  localparam int KMI_INHIBIT_CYCLES = 800;
  localparam int KMI_RTS_CYCLES     = 16;
  localparam int KMI_TIMEOUT_CYCLES = 16000;
  localparam int KMI_CNT_W          = 16;

endpackage

// File: rtl/kmi_sync2.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable
// reset value so an idle-high line does not read as active out of reset.
`timescale 1ns/1ps
module kmi_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops give the first stage a full cycle to settle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/kmi_line_sequencer.sv
// KMI line sequencer: owns the shared clock/data lines, arbitrates between
// device-initiated receive and host-initiated transmit, runs the host
// request-to-send sequence and waits for the line to recover afterwards.
// Build option: define KMI_WATCHDOG_EN to enable the RX/TX timeout abort;
// without it RX and TX wait indefinitely and tx_err/rx_timeout stay 0.
`timescale 1ns/1ps
module kmi_line_sequencer
  import kmi_pkg::*;
#(
  parameter int INHIBIT_CYCLES = KMI_INHIBIT_CYCLES,
  parameter int RTS_CYCLES     = KMI_RTS_CYCLES,
  parameter int TIMEOUT_CYCLES = KMI_TIMEOUT_CYCLES,
  parameter int CNT_W          = KMI_CNT_W
) (
  input  logic       ref_clk,
  input  logic       nreset,
  input  logic       tx_req,
  output logic       tx_start,
  input  logic       tx_done,
  output logic       tx_ack,
  output logic       tx_err,
  output logic       rx_en,
  input  logic       rx_busy,
  input  logic       rx_done,
  output logic       rx_timeout,
  input  logic       clk_in,
  output logic       nclk_en,
  output logic       ndata_rts,
  output logic [2:0] state_o
);

  // The counter is loaded with N-1 on entry so a state lasts exactly N cycles
  localparam logic [CNT_W-1:0] C_INHIBIT = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_RTS     = CNT_W'(RTS_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYCLES - 1);

  kmi_seq_state_t   r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_nclk_en;
  logic             r_ndata_rts;
  logic             r_rx_en;
  logic             r_tx_start;
  logic             r_tx_ack;
  logic             r_tx_err;
  logic             r_rx_timeout;
  logic             w_clk_sync;
  logic             w_cnt_zero;
  logic             w_expired;

  kmi_sync2 #(
    .RESET_VAL(1'b1)
  ) u_clk_sync (
    .i_clk  (ref_clk),
    .i_rst_n(nreset),
    .i_d    (clk_in),
    .o_q    (w_clk_sync)
  );

  assign w_cnt_zero = (r_cnt == '0);

`ifdef KMI_WATCHDOG_EN
  assign w_expired = w_cnt_zero;
`else
  assign w_expired = 1'b0;
`endif

  // Sequencer FSM: state, shared down-counter and all registered outputs
  always_ff @(posedge ref_clk or negedge nreset) begin
    if (!nreset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_nclk_en    <= 1'b1;
      r_ndata_rts  <= 1'b1;
      r_rx_en      <= 1'b0;
      r_tx_start   <= 1'b0;
      r_tx_ack     <= 1'b0;
      r_tx_err     <= 1'b0;
      r_rx_timeout <= 1'b0;
    end else begin
      r_tx_start   <= 1'b0;
      r_tx_ack     <= 1'b0;
      r_tx_err     <= 1'b0;
      r_rx_timeout <= 1'b0;
      if (!w_cnt_zero) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      case (r_state)
        IDLE: begin
          r_rx_en     <= 1'b1;
          r_nclk_en   <= 1'b1;
          r_ndata_rts <= 1'b1;
          if (rx_busy) begin
            r_state <= RX;
            r_cnt   <= C_TIMEOUT;
          end else if (tx_req) begin
            r_state   <= INHIBIT;
            r_cnt     <= C_INHIBIT;
            r_rx_en   <= 1'b0;
            r_nclk_en <= 1'b0;
          end
        end
        RX: begin
          if (rx_done) begin
            r_state <= IDLE;
          end else if (w_expired) begin
            r_state      <= RECOVER;
            r_cnt        <= C_RTS;
            r_rx_en      <= 1'b0;
            r_rx_timeout <= 1'b1;
          end
        end
        INHIBIT: begin
          if (w_cnt_zero) begin
            r_state     <= RTS;
            r_cnt       <= C_RTS;
            r_ndata_rts <= 1'b0;
          end
        end
        RTS: begin
          if (w_cnt_zero) begin
            r_state     <= TX;
            r_cnt       <= C_TIMEOUT;
            r_nclk_en   <= 1'b1;
            r_ndata_rts <= 1'b1;
            r_tx_start  <= 1'b1;
          end
        end
        TX: begin
          if (tx_done) begin
            r_state  <= RECOVER;
            r_cnt    <= C_RTS;
            r_tx_ack <= 1'b1;
          end else if (w_expired) begin
            r_state  <= RECOVER;
            r_cnt    <= C_RTS;
            r_tx_ack <= 1'b1;
            r_tx_err <= 1'b1;
          end
        end
        RECOVER: begin
          if (!w_clk_sync) begin
            r_cnt <= C_RTS;
          end else if (w_cnt_zero) begin
            r_state <= IDLE;
            r_rx_en <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_nclk_en   <= 1'b1;
          r_ndata_rts <= 1'b1;
          r_rx_en     <= 1'b0;
        end
      endcase
    end
  end

  assign nclk_en    = r_nclk_en;
  assign ndata_rts  = r_ndata_rts;
  assign rx_en      = r_rx_en;
  assign tx_start   = r_tx_start;
  assign tx_ack     = r_tx_ack;
  assign tx_err     = r_tx_err;
  assign rx_timeout = r_rx_timeout;
  assign state_o    = r_state;

endmodule

// File: tb/tb_kmi_line_sequencer.sv
// Self-checking bench for kmi_line_sequencer. Expected waveforms come from a
// cycle-indexed model derived from the protocol timing (inhibit, RTS, TX,
// recovery run-length), not from the sequencer's own state machine.
`timescale 1ns/1ps
module tb_kmi_line_sequencer;

  localparam int INH  = 8;
  localparam int RTSC = 2;
  localparam int TMO  = 50;

  logic       ref_clk = 1'b0;
  logic       nreset  = 1'b0;
  logic       tx_req  = 1'b0;
  logic       tx_done = 1'b0;
  logic       rx_busy = 1'b0;
  logic       rx_done = 1'b0;
  logic       clk_in  = 1'b1;
  logic       tx_start;
  logic       tx_ack;
  logic       tx_err;
  logic       rx_en;
  logic       rx_timeout;
  logic       nclk_en;
  logic       ndata_rts;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;
  bit clkPat [0:255];

  kmi_line_sequencer #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES    (RTSC),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (16)
  ) dut (
    .ref_clk   (ref_clk),
    .nreset    (nreset),
    .tx_req    (tx_req),
    .tx_start  (tx_start),
    .tx_done   (tx_done),
    .tx_ack    (tx_ack),
    .tx_err    (tx_err),
    .rx_en     (rx_en),
    .rx_busy   (rx_busy),
    .rx_done   (rx_done),
    .rx_timeout(rx_timeout),
    .clk_in    (clk_in),
    .nclk_en   (nclk_en),
    .ndata_rts (ndata_rts),
    .state_o   (state_o)
  );

  // Free-running reference clock, 10 ns period
  always #5 ref_clk = ~ref_clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: observed=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge ref_clk);
    #1;
  endtask

  // Drive all DUT inputs for the current cycle
  task automatic applyStimulus(input logic txReq, input logic txDone, input logic rxBusy,
                               input logic rxDone, input logic clkIn);
    tx_req  = txReq;
    tx_done = txDone;
    rx_busy = rxBusy;
    rx_done = rxDone;
    clk_in  = clkIn;
  endtask

  // One comparison: counts it, asserts equality, reports on mismatch
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model's values for this cycle
  task automatic checkAll(input string p, input int c, input int es, input bit enclk,
                          input bit endata, input bit erx, input bit estart, input bit eack,
                          input bit eerr, input bit erxto);
    checkOutput($sformatf("%s c=%0d state_o", p, c), 8'(state_o), 8'(es));
    checkOutput($sformatf("%s c=%0d nclk_en", p, c), 8'(nclk_en), 8'(enclk));
    checkOutput($sformatf("%s c=%0d ndata_rts", p, c), 8'(ndata_rts), 8'(endata));
    checkOutput($sformatf("%s c=%0d rx_en", p, c), 8'(rx_en), 8'(erx));
    checkOutput($sformatf("%s c=%0d tx_start", p, c), 8'(tx_start), 8'(estart));
    checkOutput($sformatf("%s c=%0d tx_ack", p, c), 8'(tx_ack), 8'(eack));
    checkOutput($sformatf("%s c=%0d tx_err", p, c), 8'(tx_err), 8'(eerr));
    checkOutput($sformatf("%s c=%0d rx_timeout", p, c), 8'(rx_timeout), 8'(erxto));
  endtask

  // Reset the DUT, check the reset values, and leave it idle with lines high
  task automatic applyReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    nreset = 1'b0;
    repeat (2) tick();
    checkAll("reset", 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    nreset = 1'b1;
    repeat (4) tick();
  endtask

  // Host transmit. d >= 0: tx_done d cycles after tx_start; d < 0: no tx_done.
  // mode 0: clk_in stays high, 1: alternating lows in recovery, 2: random lows.
  task automatic runTx(input int d, input int mode);
    int tS, doneC, ackC, idleC, run, es;
    bit expErr;
    tS     = INH + RTSC + 1;
    expErr = (d < 0);
    doneC  = expErr ? tS + TMO - 1 : tS + d;
    ackC   = doneC + 1;
    for (int k = 0; k < 256; k++) clkPat[k] = 1'b1;
    if (mode == 1) begin
      for (int k = ackC - 2; k < ackC + 7; k++) clkPat[k] = ((k - ackC) % 2 != 0);
    end else if (mode == 2) begin
      for (int k = ackC - 2; k < ackC + 10; k++) clkPat[k] = ($urandom_range(0, 2) != 0);
    end
    // Recovery ends after RTSC consecutive high samples seen two cycles late
    idleC = ackC + 200;
    run   = 0;
    for (int c = ackC; c < ackC + 64; c++) begin
      if (clkPat[c - 2]) run++;
      else run = 0;
      if (run >= RTSC) begin
        idleC = c + 1;
        break;
      end
    end
    for (int c = 0; c <= idleC + 2; c++) begin
      applyStimulus(c < ackC, !expErr && (c == doneC), 1'b0, 1'b0, clkPat[c]);
      es = (c == 0) ? 0 : (c <= INH) ? 2 : (c <= INH + RTSC) ? 3 :
           (c <= doneC) ? 4 : (c < idleC) ? 5 : 0;
      checkAll($sformatf("tx d=%0d m=%0d", d, mode), c, es,
               !(c >= 1 && c <= INH + RTSC), !(c > INH && c <= INH + RTSC),
               (c == 0) || (c >= idleC), c == tS, c == ackC, expErr && (c == ackC), 1'b0);
      tick();
    end
  endtask

  initial begin
    int r, es;
    $display("[TB] start");
    applyReset();

    // Transmit with various completion delays and recovery line patterns
    runTx(9, 0);
    runTx($urandom_range(1, 30), 1);
    runTx($urandom_range(1, 30), 2);
    runTx($urandom_range(1, 30), 2);

    // Receive and transmit requested together: receive wins, transmit follows
    r = $urandom_range(1, 20);
    for (int c = 0; c <= r + 2 + INH; c++) begin
      applyStimulus(1'b1, 1'b0, c == 0, c == r, 1'b1);
      es = (c == 0) ? 0 : (c <= r) ? 1 : (c == r + 1) ? 0 : (c < r + 2 + INH) ? 2 : 3;
      checkAll("collide", c, es, c < r + 2, c < r + 2 + INH, c <= r + 1,
               1'b0, 1'b0, 1'b0, 1'b0);
      if (c < r + 2 + INH) tick();
    end

    // Reset asserted mid-RTS releases the lines at once without an ack
    nreset = 1'b0;
    #1;
    checkAll("rst_in_rts", 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) tick();
    #2;
    nreset = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checkAll("after_rst", c, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end

`ifdef KMI_WATCHDOG_EN
    // Transmitter never finishes: abort with an error ack
    runTx(-1, 0);

    // Receiver never finishes: abort into recovery with a timeout pulse
    for (int c = 0; c <= TMO + 4; c++) begin
      applyStimulus(1'b0, 1'b0, c == 0, 1'b0, 1'b1);
      es = (c == 0) ? 0 : (c <= TMO) ? 1 : (c <= TMO + 2) ? 5 : 0;
      checkAll("rx_tmo", c, es, 1'b1, 1'b1, !(c == TMO + 1 || c == TMO + 2),
               1'b0, 1'b0, 1'b0, c == TMO + 1);
      tick();
    end
`else
    // Without the watchdog a silent transmitter holds the sequencer in TX
    for (int c = 0; c <= INH + RTSC + 1 + TMO + 20; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      es = (c == 0) ? 0 : (c <= INH) ? 2 : (c <= INH + RTSC) ? 3 : 4;
      checkAll("tx_hang", c, es, !(c >= 1 && c <= INH + RTSC),
               !(c > INH && c <= INH + RTSC), c == 0, c == INH + RTSC + 1,
               1'b0, 1'b0, 1'b0);
      tick();
    end
    applyReset();

    // Likewise a silent receiver holds the sequencer in RX
    for (int c = 0; c <= TMO + 20; c++) begin
      applyStimulus(1'b0, 1'b0, c == 0, 1'b0, 1'b1);
      checkAll("rx_hang", c, (c == 0) ? 0 : 1, 1'b1, 1'b1, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    applyReset();
`endif

    // Sequencer must still work normally afterwards
    runTx($urandom_range(1, 30), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
